// File: rtl/icache_refill_if.sv
// Fill-port, miss-request and RAM-port signals shared between the refill
// engine and its neighbours (the icache and the byte-wide RAM).
interface icache_refill_if #(
  parameter int ADDR_WIDTH = 32
);
  // icache side
  logic                  memfetchEn;
  logic [ADDR_WIDTH-1:0] memfetchAddr;
  logic                  addEn;
  logic [31:0]           addInst;
  logic [ADDR_WIDTH-1:0] addAddr;
  logic                  busy;
  // RAM side
  logic [7:0]            mem_din;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;

  // Refill engine view.
  modport master (
    input  memfetchEn, memfetchAddr, mem_din,
    output addEn, addInst, addAddr, busy, mem_a, mem_wr
  );

  // icache / RAM view.
  modport slave (
    output memfetchEn, memfetchAddr, mem_din,
    input  addEn, addInst, addAddr, busy, mem_a, mem_wr
  );
endinterface

// File: rtl/icache_refill.sv
// Instruction-cache refill responder: on a miss, reads four consecutive bytes
// from a byte-wide synchronous RAM, assembles them little-endian and returns
// the word to the icache as a one-cycle fill pulse.
module icache_refill #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            clear,
  icache_refill_if.master bus
);

  // S_CAP is the capture-b3 step; S_STALL parks a read that lost rdy until
  // rdy returns, so the restart re-issues base one cycle before RD0 and the
  // RAM pipeline lines up with the byte counter again.
  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_CAP, S_DONE, S_STALL
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [23:0]           bytes_q, bytes_d;
  logic                  add_en_q, add_en_d;
  logic [31:0]           add_inst_q, add_inst_d;
  logic [ADDR_WIDTH-1:0] add_addr_q, add_addr_d;
  logic                  busy_q, busy_d;

  logic in_read;
  assign in_read = (state_q != S_IDLE) && (state_q != S_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: clear wins, then a stall, then the normal sequence.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else if (!rdy) begin
      if (in_read) state_d = S_STALL;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.memfetchEn) state_d = S_RD0;
        S_RD0:   state_d = S_RD1;
        S_RD1:   state_d = S_RD2;
        S_RD2:   state_d = S_RD3;
        S_RD3:   state_d = S_CAP;
        S_CAP:   state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        S_STALL: state_d = S_RD0;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath / output next values; every output is registered below.
  always_comb begin
    base_d     = base_q;
    mem_a_d    = mem_a_q;
    cnt_d      = cnt_q;
    bytes_d    = bytes_q;
    add_en_d   = add_en_q;
    add_inst_d = add_inst_q;
    add_addr_d = add_addr_q;
    if (clear) begin
      add_en_d = 1'b0;
      cnt_d    = 2'd0;
      bytes_d  = '0;
    end else if (!rdy) begin
      if (in_read) begin
        mem_a_d = base_q;
        cnt_d   = 2'd0;
        bytes_d = '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.memfetchEn) begin
            base_d  = bus.memfetchAddr;
            mem_a_d = bus.memfetchAddr;
          end
        end
        S_RD0: begin
          mem_a_d = base_q + ADDR_WIDTH'(1);
          cnt_d   = 2'd0;
        end
        S_RD1, S_RD2, S_RD3: begin
          bytes_d[{cnt_q, 3'b000} +: 8] = bus.mem_din;
          cnt_d = cnt_q + 2'd1;
          if (state_q == S_RD1) mem_a_d = base_q + ADDR_WIDTH'(2);
          if (state_q == S_RD2) mem_a_d = base_q + ADDR_WIDTH'(3);
        end
        S_CAP: begin
          add_inst_d = {bus.mem_din, bytes_q};
          add_addr_d = base_q;
          add_en_d   = 1'b1;
        end
        S_DONE:  add_en_d = 1'b0;
        S_STALL: mem_a_d = base_q;
        default: ;
      endcase
    end
  end

  assign busy_d = (state_d != S_IDLE);

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q     <= '0;
      mem_a_q    <= '0;
      cnt_q      <= 2'd0;
      bytes_q    <= '0;
      add_en_q   <= 1'b0;
      add_inst_q <= '0;
      add_addr_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      base_q     <= base_d;
      mem_a_q    <= mem_a_d;
      cnt_q      <= cnt_d;
      bytes_q    <= bytes_d;
      add_en_q   <= add_en_d;
      add_inst_q <= add_inst_d;
      add_addr_q <= add_addr_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.mem_a   = mem_a_q;
  assign bus.mem_wr  = 1'b0;
  assign bus.addEn   = add_en_q;
  assign bus.addInst = add_inst_q;
  assign bus.addAddr = add_addr_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: table of basic fills plus hand-written
// sequences for persistence, clear, stall and asynchronous reset.
module tb_icache_refill;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic clear = 1'b0;

  icache_refill_if #(.ADDR_WIDTH(32)) bus ();

  icache_refill #(.ADDR_WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Byte-wide synchronous RAM, 1 KiB aliased over the address space.
  logic [7:0] ram [0:1023];
  always @(posedge clk) bus.mem_din <= ram[bus.mem_a[9:0]];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_inst;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected outputs k cycles after the accepting edge of a clean fill.
  task automatic check_cycle(input int k, input logic [31:0] addr, input logic [31:0] exp);
    if (k <= 3) chk($sformatf("mem_a E%0d", k), bus.mem_a, addr + 32'(k));
    chk($sformatf("addEn E%0d", k), {31'b0, bus.addEn}, (k == 5) ? 32'd1 : 32'd0);
    chk($sformatf("busy E%0d", k), {31'b0, bus.busy}, (k < 6) ? 32'd1 : 32'd0);
    if (k == 5) begin
      chk("addInst", bus.addInst, exp);
      chk("addAddr", bus.addAddr, addr);
    end
  endtask

  // Issue a request at the current negedge and follow it through E6.
  task automatic fill(input logic [31:0] addr, input logic [31:0] exp, input bit hold);
    bus.memfetchEn   = 1'b1;
    bus.memfetchAddr = addr;
    for (int k = 0; k <= 6; k++) begin
      tick();
      if (k == 0 && !hold) bus.memfetchEn = 1'b0;
      if (k == 1) bus.memfetchAddr = ~addr;  // must be ignored mid-fetch
      check_cycle(k, addr, exp);
    end
    $display("fill addr=%h inst=%h exp=%h", addr, bus.addInst, exp);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i);
    ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'hA0; ram[10'h103] = 8'h00;
    ram[10'h200] = 8'h78; ram[10'h201] = 8'h56; ram[10'h202] = 8'h34; ram[10'h203] = 8'h12;
    ram[10'h3FE] = 8'hEF; ram[10'h3FF] = 8'hBE; ram[10'h000] = 8'hAD; ram[10'h001] = 8'hDE;

    vecs[0] = '{addr: 32'h0000_0100, exp_inst: 32'h00A0_0513};
    vecs[1] = '{addr: 32'h0000_0200, exp_inst: 32'h1234_5678};
    vecs[2] = '{addr: 32'hFFFF_FFFE, exp_inst: 32'hDEAD_BEEF};
    vecs[3] = '{addr: 32'h0000_0300, exp_inst: 32'h0302_0100};
    vecs[4] = '{addr: 32'h0000_00FC, exp_inst: 32'hFFFE_FDFC};

    bus.memfetchEn   = 1'b0;
    bus.memfetchAddr = 32'h0;

    // Reset held across a few edges.
    tick(); tick();
    chk("reset mem_a", bus.mem_a, 32'h0);
    chk("reset addEn", {31'b0, bus.addEn}, 32'h0);
    chk("reset addInst", bus.addInst, 32'h0);
    chk("reset addAddr", bus.addAddr, 32'h0);
    chk("reset busy", {31'b0, bus.busy}, 32'h0);
    chk("mem_wr", {31'b0, bus.mem_wr}, 32'h0);
    rst = 1'b1;
    tick();

    // Table-driven basic fills (includes the wrap case).
    for (int v = 0; v < 5; v++) fill(vecs[v].addr, vecs[v].exp_inst, 1'b0);

    // Persistent request: not re-accepted at E6, re-accepted at E7.
    fill(32'h100, 32'h00A0_0513, 1'b1);
    bus.memfetchAddr = 32'h100;
    tick();
    bus.memfetchEn = 1'b0;
    check_cycle(0, 32'h100, 32'h00A0_0513);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_cycle(k, 32'h100, 32'h00A0_0513);
    end
    $display("persist re-fill addr=%h inst=%h", bus.addAddr, bus.addInst);

    // Clear pulsed at E3, new request at E4 fills at E9.
    bus.memfetchEn = 1'b1; bus.memfetchAddr = 32'h100;
    tick();
    bus.memfetchEn = 1'b0;
    tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear busy", {31'b0, bus.busy}, 32'h0);
    chk("clear addEn", {31'b0, bus.addEn}, 32'h0);
    fill(32'h200, 32'h1234_5678, 1'b0);

    // rdy low in IDLE: request is not accepted.
    rdy = 1'b0; bus.memfetchEn = 1'b1; bus.memfetchAddr = 32'h200;
    tick();
    chk("stall idle busy", {31'b0, bus.busy}, 32'h0);
    // Stall at E3..E4 mid-read, restart at E5, fill at E10.
    rdy = 1'b1;
    tick();
    bus.memfetchEn = 1'b0;
    check_cycle(0, 32'h200, 32'h1234_5678);
    tick(); check_cycle(1, 32'h200, 32'h1234_5678);
    tick(); check_cycle(2, 32'h200, 32'h1234_5678);
    rdy = 1'b0;
    tick();
    chk("stall E3 mem_a", bus.mem_a, 32'h200);
    chk("stall E3 busy", {31'b0, bus.busy}, 32'h1);
    tick();
    chk("stall E4 mem_a", bus.mem_a, 32'h200);
    chk("stall E4 addEn", {31'b0, bus.addEn}, 32'h0);
    rdy = 1'b1;
    for (int j = 0; j <= 6; j++) begin
      tick();
      check_cycle(j, 32'h200, 32'h1234_5678);
    end
    $display("stall fill addr=%h inst=%h", bus.addAddr, bus.addInst);

    // Asynchronous reset while in RD2, between edges.
    bus.memfetchEn = 1'b1; bus.memfetchAddr = 32'h300;
    tick();
    bus.memfetchEn = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("async mem_a", bus.mem_a, 32'h0);
    chk("async addInst", bus.addInst, 32'h0);
    chk("async addAddr", bus.addAddr, 32'h0);
    chk("async busy", {31'b0, bus.busy}, 32'h0);
    chk("async addEn", {31'b0, bus.addEn}, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("post-reset busy", {31'b0, bus.busy}, 32'h0);
    fill(32'h300, 32'h0302_0100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
# icache_refill

Refill responder for the instruction cache. It accepts a miss request (`memfetchEn`/`memfetchAddr`) and reads four consecutive bytes from the byte-wide synchronous RAM. It assembles them little-endian into one 32-bit instruction word and returns it on the cache's fill port (`addEn`/`addInst`/`addAddr`) as a one-cycle pulse. It sits between the icache and the RAM port.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: width of request, fill and RAM addresses.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `rdy`  in  1: global ready. Low means stall (see Operation).
- `clear`  in  1: synchronous abort, asserted on branch flush.
- `memfetchEn`  in  1: miss request from the icache; level, held while the miss persists.
- `memfetchAddr`  in  ADDR_WIDTH: word address of the miss.
- `mem_din`  in  8: RAM read data; equals ram[`mem_a` sampled at the previous edge].
- `mem_a`  out  ADDR_WIDTH: registered RAM byte address.
- `mem_wr`  out  1: RAM write strobe; constant 0.
- `addEn`  out  1: registered fill strobe to the icache, one cycle per word.
- `addInst`  out  32: assembled word {b3,b2,b1,b0}.
- `addAddr`  out  ADDR_WIDTH: base address of the word.
- `busy`  out  1: high in every state except IDLE.

## Operation
- States: IDLE, RD0, RD1, RD2, RD3, DONE. A 2-bit byte counter and a base register hold the in-flight request.
- Reset (asynchronous, `rst`=0) forces state=IDLE and base=0. Outputs reset to `mem_a`=0, `mem_wr`=0, `addEn`=0, `addInst`=0, `addAddr`=0, `busy`=0.
- IDLE, with `memfetchEn`=1, `rdy`=1 and `clear`=0:
  - base <= `memfetchAddr`; `mem_a` <= `memfetchAddr`.
  - Go to RD0.
- RD0: `mem_a` <= base+1; go to RD1.
- RD1: capture b0 = `mem_din`; `mem_a` <= base+2; go to RD2.
- RD2: capture b1; `mem_a` <= base+3; go to RD3.
- RD3: capture b2; go to the capture-b3 step.
- Capture-b3 (the cycle after RD3):
  - Capture b3.
  - `addInst` <= {b3,b2,b1,b0}; `addAddr` <= base; `addEn` <= 1.
  - Go to DONE.
- DONE: `addEn` <= 0; go to IDLE. The request is not resampled on this edge, because the icache still reports a miss for the word being written.
- Address arithmetic is base+k modulo 2^ADDR_WIDTH. 0xFFFFFFFE reads FE, FF, 00, 01.
- Requests are not re-sampled mid-fetch. A change of `memfetchAddr` while busy is ignored, and the latched fetch completes.
- `clear`=1 at any edge (independent of `rdy`): state <= IDLE, `addEn` <= 0, partial bytes discarded. If `addEn` was already high that cycle, the word is still valid for `addAddr`, and caching it is harmless.
- `rdy`=0 at an edge:
  - In IDLE or DONE: all registers hold.
  - In RD0..RD3 and capture-b3: partial bytes are discarded, `mem_a` <= base, and state <= RD0 once `rdy` returns. Base is kept, so the fetch restarts from byte 0. This avoids a RAM-pipeline mismatch after the stall.
- `mem_wr` is tied to 0; this block never writes RAM.

## Timing
- Request accepted at edge E0. `mem_a` sequence is base, base+1, base+2, base+3 over E0..E3.
- Bytes are captured at E2..E5. `addEn` is high from E5 to E6; the icache writes at E6.
- Back-to-back requests are accepted no earlier than E7, giving 7-cycle throughput per word.
- Each `rdy`-low edge during a read adds a full restart: 5 cycles from the first edge with `rdy`=1 to `addEn`.
- Nothing is combinational between inputs and outputs; all outputs are registered.

## Test plan
- Basic fill: RAM[0x100..0x103]=13,05,A0,00; request 0x100 at E0. Expect `addEn`=1 at E5 only, with `addInst`=0x00A00513 and `addAddr`=0x100. `busy` is low from E6.
- Persistent request: `memfetchEn` held high through E6, and held high through E7 (icache hit clears it after E6 in a real system). Expect no acceptance at E6; re-acceptance at E7 if still high.
- Wrap: request 0xFFFFFFFE. Expect `mem_a` FFFFFFFE, FFFFFFFF, 0, 1 and assembly {ram[1],ram[0],ram[FF..FF],ram[FF..FE]}.
- Clear mid-fetch: `clear` pulsed at E3. Expect state IDLE at E4, no `addEn`, and a new request 0x200 at E4 fills correctly at E9.
- Stall: `rdy`=0 at E3–E4. Expect `mem_a`=base at E4 and the restart from RD0 at E5. `addEn` occurs at E10 with the correct word.
- Async reset: `rst` low mid-RD2, between edges. Expect all outputs 0 immediately, and IDLE after release.
